// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage
// Brief    : RV32I execute stage with ALU, branch/jump resolution and the
//            exe->mem pipeline registers. The iterative RV32M multiplier is
//            built only when EXE_MUL_UNIT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module exe_stage #(
  parameter int XLEN      = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            kill_i,
  input  logic [XLEN-1:0] exe_read_data_a_i,
  input  logic [XLEN-1:0] exe_read_data_b_i,
  input  logic [XLEN-1:0] exe_write_addr_i,
  input  logic            exe_int_write_enable_i,
  input  logic [XLEN-1:0] exe_instruction_i,
  input  logic [XLEN-1:0] exe_pc_i,
  output logic            stall_core_o,
  output logic            branch_taken_o,
  output logic [XLEN-1:0] branch_target_o,
  output logic [XLEN-1:0] mem_alu_result_o,
  output logic [XLEN-1:0] mem_store_data_o,
  output logic [XLEN-1:0] mem_write_addr_o,
  output logic            mem_int_write_enable_o,
  output logic [XLEN-1:0] mem_instruction_o,
  output logic [XLEN-1:0] mem_pc_o
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_MEXT    = 7'b0000001;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_a, w_b, w_pc, w_ins;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [XLEN-1:0] w_op_b, w_alu, w_result, w_target, w_res_final;
  logic [4:0]      w_shamt;
  logic            w_cmp, w_take, w_wen, w_wen_final;

  assign w_a      = exe_read_data_a_i;
  assign w_b      = exe_read_data_b_i;
  assign w_pc     = exe_pc_i;
  assign w_ins    = exe_instruction_i;
  assign w_opcode = w_ins[6:0];
  assign w_funct3 = w_ins[14:12];
  assign w_funct7 = w_ins[31:25];
  assign w_imm_i  = {{20{w_ins[31]}}, w_ins[31:20]};
  assign w_imm_s  = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
  assign w_imm_b  = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
  assign w_imm_u  = {w_ins[31:12], 12'b0};
  assign w_imm_j  = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};

  // OP-IMM shares the ALU; only register-register ADD can become SUB
  assign w_op_b  = (w_opcode == OPC_OP) ? w_b : w_imm_i;
  assign w_shamt = w_op_b[4:0];

  always_comb begin
    w_alu = '0;
    case (w_funct3)
      3'b000:  w_alu = ((w_opcode == OPC_OP) && w_funct7[5]) ? (w_a - w_op_b) : (w_a + w_op_b);
      3'b001:  w_alu = w_a << w_shamt;
      3'b010:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_op_b))};
      3'b011:  w_alu = {{(XLEN-1){1'b0}}, (w_a < w_op_b)};
      3'b100:  w_alu = w_a ^ w_op_b;
      3'b101:  w_alu = w_funct7[5] ? XLEN'($signed(w_a) >>> w_shamt) : (w_a >> w_shamt);
      3'b110:  w_alu = w_a | w_op_b;
      default: w_alu = w_a & w_op_b;
    endcase
  end

  always_comb begin
    w_cmp = 1'b0;
    case (w_funct3)
      3'b000:  w_cmp = (w_a == w_b);
      3'b001:  w_cmp = (w_a != w_b);
      3'b100:  w_cmp = ($signed(w_a) <  $signed(w_b));
      3'b101:  w_cmp = ($signed(w_a) >= $signed(w_b));
      3'b110:  w_cmp = (w_a <  w_b);
      3'b111:  w_cmp = (w_a >= w_b);
      default: w_cmp = 1'b0;
    endcase
  end

  // M-extension ops land here with result 0 and no write; the multiplier overrides in DONE
  always_comb begin
    w_result = '0;
    w_wen    = exe_int_write_enable_i;
    w_take   = 1'b0;
    w_target = '0;
    case (w_opcode)
      OPC_OP: begin
        if (w_funct7 == F7_MEXT) w_wen = 1'b0;
        else                     w_result = w_alu;
      end
      OPC_OPIMM: w_result = w_alu;
      OPC_LUI:   w_result = w_imm_u;
      OPC_AUIPC: w_result = w_pc + w_imm_u;
      OPC_LOAD:  w_result = w_a + w_imm_i;
      OPC_STORE: w_result = w_a + w_imm_s;
      OPC_JAL: begin
        w_take   = 1'b1;
        w_target = w_pc + w_imm_j;
        w_result = w_pc + XLEN'(4);
      end
      OPC_JALR: begin
        w_take   = 1'b1;
        w_target = (w_a + w_imm_i) & ~XLEN'(1);
        w_result = w_pc + XLEN'(4);
      end
      OPC_BRANCH: begin
        w_wen    = 1'b0;
        w_take   = w_cmp;
        w_target = w_pc + w_imm_b;
      end
      default: w_wen = 1'b0;
    endcase
  end

`ifdef EXE_MUL_UNIT_EN
  localparam int         CNT_W   = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, mcand_q, w_prod;
  logic [XLEN-1:0]   mplier_q, w_abs_a, w_abs_b, w_mul_res;
  logic              neg_q, w_is_mul, w_neg_a, w_neg_b;

  assign w_is_mul = (w_opcode == OPC_OP) && (w_funct7 == F7_MEXT) && !w_funct3[2];
  // rs1 is signed except for MULHU; rs2 is signed only for MUL/MULH
  assign w_neg_a  = !(w_funct3[1] && w_funct3[0]) && w_a[XLEN-1];
  assign w_neg_b  = !w_funct3[1] && w_b[XLEN-1];
  assign w_abs_a  = w_neg_a ? -w_a : w_a;
  assign w_abs_b  = w_neg_b ? -w_b : w_b;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == ST_IDLE) && w_is_mul && !kill_i) begin
        acc_q    <= '0;
        mcand_q  <= {{XLEN{1'b0}}, w_abs_a};
        mplier_q <= w_abs_b;
        neg_q    <= w_neg_a ^ w_neg_b;
      end else if (state_q == ST_BUSY) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (kill_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (w_is_mul) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
        end
        ST_BUSY: if (cnt_q == CNT_W'(MUL_STEPS-1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_core_o = (state_q == ST_BUSY) ||
                   ((state_q == ST_IDLE) && w_is_mul && !kill_i);
  end

  assign w_prod      = neg_q ? -acc_q : acc_q;
  assign w_mul_res   = (w_funct3 == 3'b000) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  assign w_res_final = (state_q == ST_DONE) ? w_mul_res : w_result;
  assign w_wen_final = (state_q == ST_DONE) ? exe_int_write_enable_i : w_wen;
`else
  assign stall_core_o = 1'b0;
  assign w_res_final  = w_result;
  assign w_wen_final  = w_wen;
`endif

  assign branch_taken_o  = w_take && !kill_i && !stall_core_o && (w_ins != '0);
  assign branch_target_o = w_target;

  // A kill leaves a bubble in mem exactly as reset does
  always_ff @(posedge clk_i) begin
    if (rst_i || kill_i) begin
      mem_alu_result_o       <= '0;
      mem_store_data_o       <= '0;
      mem_write_addr_o       <= '0;
      mem_int_write_enable_o <= 1'b0;
      mem_instruction_o      <= '0;
      mem_pc_o               <= '0;
    end else if (!stall_core_o) begin
      mem_alu_result_o       <= w_res_final;
      mem_store_data_o       <= w_b;
      mem_write_addr_o       <= exe_write_addr_i;
      mem_int_write_enable_o <= w_wen_final;
      mem_instruction_o      <= w_ins;
      mem_pc_o               <= w_pc;
    end
  end

endmodule
`default_nettype wire
